// File: rtl/sensor_debouncer_if.sv
// Raw sensor pins and conditioned outputs of the two-channel sensor debouncer.
// The master side drives the raw pins; the slave side (the debouncer) drives the rest.
interface sensor_debouncer_if;
  logic       psensor_raw;
  logic       ssensor_raw;
  logic       psensor_o;
  logic       ssensor_o;
  logic       p_rise;
  logic       p_fall;
  logic       s_rise;
  logic       s_fall;
  logic [7:0] glitch_cnt;

  modport master (
    output psensor_raw, ssensor_raw,
    input  psensor_o, ssensor_o, p_rise, p_fall, s_rise, s_fall, glitch_cnt
  );

  modport slave (
    input  psensor_raw, ssensor_raw,
    output psensor_o, ssensor_o, p_rise, p_fall, s_rise, s_fall, glitch_cnt
  );
endinterface

// File: rtl/sensor_debouncer.sv
// Two-channel synchroniser + debouncer for the parking-bay sensors, with
// registered clean levels, one-cycle edge pulses and a shared saturating glitch counter.
module sensor_debouncer #(
  parameter int N_SYNC        = 2,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  sensor_debouncer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0] w_raw;
  assign w_raw = {bus.ssensor_raw, bus.psensor_raw};

  genvar ch;
  generate
    for (ch = 0; ch < 2; ch++) begin : g_ch
      logic [N_SYNC-1:0] r_sync;
      state_t            r_state;
      state_t            w_state_nxt;
      logic [CNT_W-1:0]  r_cnt;
      logic [CNT_W-1:0]  w_cnt_nxt;
      logic              w_s;
      logic              w_rise;
      logic              w_fall;
      logic              w_glitch;
      logic              w_level_nxt;
      logic              r_level;
      logic              r_rise;
      logic              r_fall;

      assign w_s = r_sync[N_SYNC-1];

      // Synchroniser shift register; only the last stage feeds the FSM.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync <= '0;
        end else begin
          r_sync <= {r_sync[N_SYNC-2:0], w_raw[ch]};
        end
      end

      // Debounce FSM state and qualification counter.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state <= ST_LOW;
          r_cnt   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_cnt   <= w_cnt_nxt;
        end
      end

      // Next-state logic: a reversal during a wait aborts it and counts as a glitch.
      always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_glitch    = 1'b0;
        case (r_state)
          ST_LOW: begin
            if (w_s) begin
              w_state_nxt = ST_WAIT_HIGH;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_LOW;
            end
          end
          ST_WAIT_HIGH: begin
            if (!w_s) begin
              w_state_nxt = ST_LOW;
              w_glitch    = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
              w_state_nxt = ST_HIGH;
              w_rise      = 1'b1;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (!w_s) begin
              w_state_nxt = ST_WAIT_LOW;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_HIGH;
            end
          end
          ST_WAIT_LOW: begin
            if (w_s) begin
              w_state_nxt = ST_HIGH;
              w_glitch    = 1'b1;
            end else if (r_cnt == CNT_LAST) begin
              w_state_nxt = ST_LOW;
              w_fall      = 1'b1;
            end else begin
              w_cnt_nxt   = r_cnt + CNT_ONE;
            end
          end
          default: begin
            w_state_nxt = ST_LOW;
            w_cnt_nxt   = '0;
          end
        endcase
        w_level_nxt = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_WAIT_LOW);
      end

      // Registered level and pulses so both change on the accepting edge.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_level <= 1'b0;
          r_rise  <= 1'b0;
          r_fall  <= 1'b0;
        end else begin
          r_level <= w_level_nxt;
          r_rise  <= w_rise;
          r_fall  <= w_fall;
        end
      end
    end
  endgenerate

  logic [8:0] w_glitch_sum;
  logic [7:0] w_glitch_nxt;
  logic [7:0] r_glitch_cnt;

  // Both channels may glitch on one edge; the sum saturates at 255.
  always_comb begin
    w_glitch_sum = {1'b0, r_glitch_cnt} + {8'd0, g_ch[0].w_glitch} + {8'd0, g_ch[1].w_glitch};
    if (w_glitch_sum > 9'd255) begin
      w_glitch_nxt = 8'd255;
    end else begin
      w_glitch_nxt = w_glitch_sum[7:0];
    end
  end

  // Shared glitch counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_glitch_cnt <= 8'd0;
    end else begin
      r_glitch_cnt <= w_glitch_nxt;
    end
  end

  assign bus.psensor_o  = g_ch[0].r_level;
  assign bus.ssensor_o  = g_ch[1].r_level;
  assign bus.p_rise     = g_ch[0].r_rise;
  assign bus.p_fall     = g_ch[0].r_fall;
  assign bus.s_rise     = g_ch[1].r_rise;
  assign bus.s_fall     = g_ch[1].r_fall;
  assign bus.glitch_cnt = r_glitch_cnt;

endmodule

// File: tb/tb_sensor_debouncer.sv
// Self-checking bench: run-length reference model compared every cycle, plus
// directed scenarios with hand-computed latencies and glitch counts.
module tb_sensor_debouncer;
  localparam int N_SYNC = 2;
  localparam int STABLE = 4;
  localparam int CNT_W  = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sensor_debouncer_if bus();

  sensor_debouncer #(.N_SYNC(N_SYNC), .STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last STABLE+1 synchronised
  // samples all differ from it; a differing run cut short is one glitch.
  logic [N_SYNC-1:0] m_sync [2];
  int                m_run  [2];
  logic              m_lvl  [2];
  logic              m_rise [2];
  logic              m_fall [2];
  int                m_g;
  logic [1:0]        raw_v;
  assign raw_v = {bus.ssensor_raw, bus.psensor_raw};

  function automatic int run_next(input logic lvl, input logic s, input int run);
    if (s == lvl) return 0;
    if (run == STABLE) return 0;
    return run + 1;
  endfunction

  function automatic logic accepts(input logic lvl, input logic s, input int run);
    return (s != lvl) && (run == STABLE);
  endfunction

  function automatic int glitch(input logic lvl, input logic s, input int run);
    return ((s == lvl) && (run > 0)) ? 1 : 0;
  endfunction

  function automatic int sat_add(input int g, input int n);
    return (g + n > 255) ? 255 : g + n;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        m_sync[c] <= '0;
        m_run[c]  <= 0;
        m_lvl[c]  <= 1'b0;
        m_rise[c] <= 1'b0;
        m_fall[c] <= 1'b0;
      end
      m_g <= 0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        m_sync[c] <= {m_sync[c][N_SYNC-2:0], raw_v[c]};
        m_run[c]  <= run_next(m_lvl[c], m_sync[c][N_SYNC-1], m_run[c]);
        m_rise[c] <= accepts(m_lvl[c], m_sync[c][N_SYNC-1], m_run[c]) && m_sync[c][N_SYNC-1];
        m_fall[c] <= accepts(m_lvl[c], m_sync[c][N_SYNC-1], m_run[c]) && !m_sync[c][N_SYNC-1];
        if (accepts(m_lvl[c], m_sync[c][N_SYNC-1], m_run[c])) m_lvl[c] <= m_sync[c][N_SYNC-1];
        else m_lvl[c] <= m_lvl[c];
      end
      m_g <= sat_add(m_g, glitch(m_lvl[0], m_sync[0][N_SYNC-1], m_run[0])
                        + glitch(m_lvl[1], m_sync[1][N_SYNC-1], m_run[1]));
    end
  end

  always @(negedge clk) begin
    chk("model_psensor_o", bus.psensor_o, m_lvl[0]);
    chk("model_ssensor_o", bus.ssensor_o, m_lvl[1]);
    chk("model_p_rise", bus.p_rise, m_rise[0]);
    chk("model_p_fall", bus.p_fall, m_fall[0]);
    chk("model_s_rise", bus.s_rise, m_rise[1]);
    chk("model_s_fall", bus.s_fall, m_fall[1]);
    chk("model_glitch_cnt", bus.glitch_cnt, m_g);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_g;
  int n_rise;
  int n_fall;
  int hold [2];

  initial begin
    bus.psensor_raw = 1'b1;
    bus.ssensor_raw = 1'b1;
    reset_n = 1'b0;
    exp_g = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_psensor_o", bus.psensor_o, 0);
    chk("rst_ssensor_o", bus.ssensor_o, 0);
    chk("rst_p_rise", bus.p_rise, 0);
    chk("rst_s_rise", bus.s_rise, 0);
    chk("rst_glitch", bus.glitch_cnt, 0);

    // Release with both sensors high: rise on the 7th edge after release.
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk("rel_psensor_o", bus.psensor_o, (i == 7));
      chk("rel_ssensor_o", bus.ssensor_o, (i == 7));
      chk("rel_p_rise", bus.p_rise, (i == 7));
      chk("rel_s_rise", bus.s_rise, (i == 7));
    end
    tick();
    chk("rel_p_rise_once", bus.p_rise, 0);
    chk("rel_s_rise_once", bus.s_rise, 0);
    chk("rel_glitch", bus.glitch_cnt, 0);

    bus.psensor_raw = 1'b0;
    bus.ssensor_raw = 1'b0;
    repeat (8) tick();
    chk("low_levels", {bus.psensor_o, bus.ssensor_o}, 0);

    // Pulse widths 3 and 4 are rejected as one glitch each; 5 is accepted.
    for (int w = 3; w <= 5; w++) begin
      n_rise = 0;
      n_fall = 0;
      bus.psensor_raw = 1'b1;
      for (int i = 1; i <= 16; i++) begin
        if (i > w) bus.psensor_raw = 1'b0;
        tick();
        n_rise += int'(bus.p_rise);
        n_fall += int'(bus.p_fall);
      end
      if (w < 5) exp_g++;
      chk("width_rise_count", n_rise, (w == 5) ? 1 : 0);
      chk("width_fall_count", n_fall, (w == 5) ? 1 : 0);
      chk("width_glitch", bus.glitch_cnt, exp_g);
    end

    // p up, s up, s down, p down at 10-cycle spacing: pulses 6 edges after capture.
    for (int i = 1; i <= 45; i++) begin
      if (i == 1)  bus.psensor_raw = 1'b1;
      if (i == 11) bus.ssensor_raw = 1'b1;
      if (i == 21) bus.ssensor_raw = 1'b0;
      if (i == 31) bus.psensor_raw = 1'b0;
      tick();
      chk("seq_p_rise", bus.p_rise, (i == 7));
      chk("seq_s_rise", bus.s_rise, (i == 17));
      chk("seq_s_fall", bus.s_fall, (i == 27));
      chk("seq_p_fall", bus.p_fall, (i == 37));
    end
    chk("seq_glitch", bus.glitch_cnt, exp_g);

    // Bounce on release: 0,1,0,0,... gives one glitch, then fall.
    bus.psensor_raw = 1'b1;
    repeat (8) tick();
    chk("bounce_start_level", bus.psensor_o, 1);
    for (int i = 1; i <= 14; i++) begin
      bus.psensor_raw = (i == 2);
      tick();
      chk("bounce_p_fall", bus.p_fall, (i == 9));
    end
    exp_g++;
    chk("bounce_glitch", bus.glitch_cnt, exp_g);

    // Single p glitch, then simultaneous pairs up to and beyond saturation.
    bus.psensor_raw = 1'b1;
    repeat (2) tick();
    bus.psensor_raw = 1'b0;
    repeat (6) tick();
    exp_g++;
    chk("single_glitch", bus.glitch_cnt, exp_g);
    while (exp_g < 256) begin
      bus.psensor_raw = 1'b1;
      bus.ssensor_raw = 1'b1;
      repeat (2) tick();
      bus.psensor_raw = 1'b0;
      bus.ssensor_raw = 1'b0;
      repeat (6) tick();
      exp_g += 2;
      chk("pair_glitch", bus.glitch_cnt, (exp_g > 255) ? 255 : exp_g);
    end
    chk("sat_levels", {bus.psensor_o, bus.ssensor_o}, 0);
    bus.psensor_raw = 1'b1;
    repeat (2) tick();
    bus.psensor_raw = 1'b0;
    repeat (6) tick();
    chk("sat_hold", bus.glitch_cnt, 255);

    // Reset while in WAIT_HIGH with cnt = 2.
    bus.psensor_raw = 1'b1;
    repeat (5) tick();
    reset_n = 1'b0;
    #1;
    chk("midrst_psensor_o", bus.psensor_o, 0);
    chk("midrst_p_rise", bus.p_rise, 0);
    chk("midrst_glitch", bus.glitch_cnt, 0);
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("midrst_rel_level", bus.psensor_o, (i >= 7));
      chk("midrst_rel_rise", bus.p_rise, (i == 7));
    end
    chk("midrst_rel_glitch", bus.glitch_cnt, 0);

    // Randomised hold times, with one asynchronous reset pulse mid-run.
    hold[0] = 0;
    hold[1] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold[0] == 0) begin
        bus.psensor_raw = 1'($urandom_range(0, 1));
        hold[0] = $urandom_range(1, 8);
      end
      if (hold[1] == 0) begin
        bus.ssensor_raw = 1'($urandom_range(0, 1));
        hold[1] = $urandom_range(1, 8);
      end
      hold[0]--;
      hold[1]--;
      if (cyc == 1500) begin
        #2;
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
